// File: rtl/downsampler_variable_mc.sv
// Keeps one complete channel-interleaved frame out of every R frames; rate changes wait for a period boundary.
// Latency: 1 clk from accepted input beat to output valid. Optional DOWNSAMPLER_PHASE_OFFSET_EN selects the kept frame.
// Backpressure: s_axis_in_tready = !m_axis_out_tvalid || m_axis_out_tready, also for beats that get discarded.
module downsampler_variable_mc #(
  parameter int DATA_WIDTH_INP  = 8,
  parameter int DATA_WIDTH_RATE = 16,
  parameter int NUM_CH          = 2,
  parameter int CH_WIDTH        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
  input  logic                       s_axis_in_tvalid,
  output logic                       s_axis_in_tready,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
  input  logic                       s_axis_rate_tvalid,
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_phase_tdata,
`endif
  output logic [DATA_WIDTH_INP-1:0]  m_axis_out_tdata,
  output logic                       m_axis_out_tvalid,
  input  logic                       m_axis_out_tready,
  output logic [CH_WIDTH-1:0]        m_axis_out_tuser,
  output logic                       m_axis_out_tlast,
  output logic [DATA_WIDTH_RATE-1:0] rate_active
);

  localparam logic [CH_WIDTH-1:0]        LP_LAST_CH = CH_WIDTH'(NUM_CH - 1);
  localparam logic [DATA_WIDTH_RATE-1:0] LP_ONE     = DATA_WIDTH_RATE'(1);

  logic [CH_WIDTH-1:0]        r_ch_cnt;
  logic [DATA_WIDTH_RATE-1:0] r_dec_cnt;
  logic [DATA_WIDTH_RATE-1:0] r_rate_active;
  logic [DATA_WIDTH_RATE-1:0] r_rate_pend_val;
  logic                       r_rate_pend;
  logic [DATA_WIDTH_INP-1:0]  r_out_dat;
  logic                       r_out_vld;
  logic [CH_WIDTH-1:0]        r_out_user;
  logic                       r_out_last;

  logic                       w_in_rdy;
  logic                       w_acc;
  logic                       w_last_ch;
  logic [DATA_WIDTH_RATE-1:0] w_rate_last;
  logic                       w_period_end;
  logic [DATA_WIDTH_RATE-1:0] w_keep_idx;
  logic                       w_keep;
  logic                       w_boundary;
  logic [DATA_WIDTH_RATE-1:0] w_rate_wr;
  logic                       w_pend_eff;
  logic [DATA_WIDTH_RATE-1:0] w_pend_val_eff;
  logic                       w_apply;

  assign w_in_rdy     = !r_out_vld || m_axis_out_tready;
  assign w_acc        = s_axis_in_tvalid && w_in_rdy;
  assign w_last_ch    = (r_ch_cnt == LP_LAST_CH);
  assign w_rate_last  = r_rate_active - LP_ONE;
  assign w_period_end = (r_dec_cnt == w_rate_last);
  assign w_keep       = (r_dec_cnt == w_keep_idx);

  // A write landing on the boundary edge is applied there, so look through the pending register.
  assign w_rate_wr      = (s_axis_rate_tdata == '0) ? LP_ONE : s_axis_rate_tdata;
  assign w_pend_eff     = r_rate_pend || s_axis_rate_tvalid;
  assign w_pend_val_eff = s_axis_rate_tvalid ? w_rate_wr : r_rate_pend_val;

  assign w_boundary = (w_acc && w_last_ch && w_period_end) ||
                      (!w_acc && (r_ch_cnt == '0) && (r_dec_cnt == '0));
  assign w_apply    = w_boundary && w_pend_eff;

`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
  logic [DATA_WIDTH_RATE-1:0] r_phase_active;
  logic [DATA_WIDTH_RATE-1:0] r_phase_pend_val;
  logic [DATA_WIDTH_RATE-1:0] w_phase_eff;
  logic [DATA_WIDTH_RATE-1:0] w_phase_apply;

  // Phase is clamped against the rate it is applied with, not the rate it was written with.
  assign w_phase_eff   = s_axis_rate_tvalid ? s_axis_phase_tdata : r_phase_pend_val;
  assign w_phase_apply = (w_phase_eff >= w_pend_val_eff) ? (w_pend_val_eff - LP_ONE) : w_phase_eff;
  assign w_keep_idx    = r_phase_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase_active   <= '0;
      r_phase_pend_val <= '0;
    end else begin
      if (s_axis_rate_tvalid) begin
        r_phase_pend_val <= s_axis_phase_tdata;
      end
      if (w_apply) begin
        r_phase_active <= w_phase_apply;
      end
    end
  end
`else
  assign w_keep_idx = w_rate_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_cnt  <= '0;
      r_dec_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_ch_cnt <= w_last_ch ? '0 : r_ch_cnt + CH_WIDTH'(1);
      end
      if (w_apply) begin
        r_dec_cnt <= '0;
      end else if (w_acc && w_last_ch) begin
        r_dec_cnt <= w_period_end ? '0 : r_dec_cnt + LP_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rate_active   <= LP_ONE;
      r_rate_pend_val <= LP_ONE;
      r_rate_pend     <= 1'b0;
    end else begin
      if (s_axis_rate_tvalid) begin
        r_rate_pend_val <= w_rate_wr;
      end
      if (w_apply) begin
        r_rate_active <= w_pend_val_eff;
        r_rate_pend   <= 1'b0;
      end else if (s_axis_rate_tvalid) begin
        r_rate_pend <= 1'b1;
      end
    end
  end

  // Discarded beats leave the output register untouched; it is never flushed on a rate change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_user <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_acc && w_keep) begin
        r_out_dat  <= s_axis_in_tdata;
        r_out_vld  <= 1'b1;
        r_out_user <= r_ch_cnt;
        r_out_last <= w_last_ch;
      end else if (m_axis_out_tready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign s_axis_in_tready  = w_in_rdy;
  assign m_axis_out_tdata  = r_out_dat;
  assign m_axis_out_tvalid = r_out_vld;
  assign m_axis_out_tuser  = r_out_user;
  assign m_axis_out_tlast  = r_out_last;
  assign rate_active       = r_rate_active;

endmodule

// File: tb/tb_downsampler_variable_mc.sv
// Directed bench for downsampler_variable_mc (NUM_CH=2, 8-bit samples, 16-bit rate).
module tb_downsampler_variable_mc;

  logic        clk;
  logic        reset_n;
  logic [7:0]  s_axis_in_tdata;
  logic        s_axis_in_tvalid;
  logic        s_axis_in_tready;
  logic [15:0] s_axis_rate_tdata;
  logic        s_axis_rate_tvalid;
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
  logic [15:0] s_axis_phase_tdata;
`endif
  logic [7:0]  m_axis_out_tdata;
  logic        m_axis_out_tvalid;
  logic        m_axis_out_tready;
  logic [0:0]  m_axis_out_tuser;
  logic        m_axis_out_tlast;
  logic [15:0] rate_active;

  int errors = 0;
  int checks = 0;

  logic [9:0] got [$];
  bit         rdy_q [$];
  int         stall_cnt = 0;
  int         stab_err  = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_dat = '0;

  downsampler_variable_mc #(
    .DATA_WIDTH_INP(8), .DATA_WIDTH_RATE(16), .NUM_CH(2), .CH_WIDTH(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
    .s_axis_in_tready(s_axis_in_tready),
    .s_axis_rate_tdata(s_axis_rate_tdata), .s_axis_rate_tvalid(s_axis_rate_tvalid),
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
    .s_axis_phase_tdata(s_axis_phase_tdata),
`endif
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
    .m_axis_out_tready(m_axis_out_tready), .m_axis_out_tuser(m_axis_out_tuser),
    .m_axis_out_tlast(m_axis_out_tlast), .rate_active(rate_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records every handshake and watches data stability while stalled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_axis_out_tvalid && m_axis_out_tready)
        got.push_back({m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast});
      if (!s_axis_in_tready) stall_cnt++;
      if (prev_stall && (!m_axis_out_tvalid || m_axis_out_tdata !== prev_dat)) stab_err++;
      prev_stall = m_axis_out_tvalid && !m_axis_out_tready;
      prev_dat   = m_axis_out_tdata;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic next_rdy();
    if (rdy_q.size() > 0) m_axis_out_tready = rdy_q.pop_front();
    else m_axis_out_tready = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      next_rdy();
    end
  endtask

  task automatic write_rate(input logic [15:0] r, input logic [15:0] ph);
    s_axis_rate_tdata  = r;
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
    s_axis_phase_tdata = ph;
`else
    if (ph != 16'hFFFF) $display("note: phase %0d ignored in this build", ph);
`endif
    s_axis_rate_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_rate_tvalid = 1'b0;
    next_rdy();
  endtask

  task automatic send_beat(input logic [7:0] d, input bit wr, input logic [15:0] r);
    bit acc  = 0;
    bit done = 0;
    s_axis_in_tdata  = d;
    s_axis_in_tvalid = 1'b1;
    if (wr) begin
      s_axis_rate_tdata  = r;
      s_axis_rate_tvalid = 1'b1;
    end
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      acc = s_axis_in_tready;
      @(posedge clk); #1;
      s_axis_rate_tvalid = 1'b0;
      next_rdy();
      if (acc) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_beat_timeout: beat %h not accepted, required acceptance within 40 clks", d);
    end
  endtask

  task automatic send_ramp(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send_beat(first + 8'(i), 1'b0, 16'd0);
    s_axis_in_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m_axis_out_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h exp 00", m_axis_out_tdata); end
    checks++; if (m_axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b exp 0", m_axis_out_tvalid); end
    checks++; if (m_axis_out_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b exp 0", m_axis_out_tuser); end
    checks++; if (m_axis_out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b exp 0", m_axis_out_tlast); end
    checks++; if (rate_active !== 16'd1) begin errors++; $display("FAIL reset_rate: got %0d exp 1", rate_active); end
    checks++; if (s_axis_in_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b exp 1", s_axis_in_tready); end
  endtask

  task automatic test_rate4();
    int base;
    logic [9:0] exp_q [$];
    exp_q = '{{8'h06,1'b0,1'b0}, {8'h07,1'b1,1'b1}, {8'h0E,1'b0,1'b0}, {8'h0F,1'b1,1'b1},
              {8'h16,1'b0,1'b0}, {8'h17,1'b1,1'b1}, {8'h1E,1'b0,1'b0}, {8'h1F,1'b1,1'b1}};
    write_rate(16'd4, 16'hFFFF);
    checks++; if (rate_active !== 16'd4) begin errors++; $display("FAIL rate4_apply: got %0d exp 4", rate_active); end
    base = got.size();
    for (int i = 0; i < 32; i++) begin
      send_beat(8'(i), 1'b0, 16'd0);
      if (i == 6) begin
        checks++; if (m_axis_out_tvalid !== 1'b1 || m_axis_out_tdata !== 8'h06)
          begin errors++; $display("FAIL rate4_latency: got vld=%b dat=%h exp vld=1 dat=06", m_axis_out_tvalid, m_axis_out_tdata); end
      end
    end
    s_axis_in_tvalid = 1'b0;
    idle(4);
    checks++; if (got.size() - base !== exp_q.size()) begin errors++; $display("FAIL rate4_count: got %0d exp %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (base + i < got.size()) begin
      checks++; if (got[base+i] !== exp_q[i]) begin errors++; $display("FAIL rate4_beat%0d: got %h exp %h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_rate0_and_1();
    int base;
    logic [9:0] exp_q [$];
    exp_q = '{{8'h40,1'b0,1'b0}, {8'h41,1'b1,1'b1}, {8'h42,1'b0,1'b0}, {8'h43,1'b1,1'b1},
              {8'h50,1'b0,1'b0}, {8'h51,1'b1,1'b1}, {8'h52,1'b0,1'b0}, {8'h53,1'b1,1'b1},
              {8'h54,1'b0,1'b0}, {8'h55,1'b1,1'b1}};
    base = got.size();
    write_rate(16'd0, 16'hFFFF);
    checks++; if (rate_active !== 16'd1) begin errors++; $display("FAIL rate0_clamp: got %0d exp 1", rate_active); end
    send_ramp(8'h40, 4);
    idle(2);
    write_rate(16'd1, 16'hFFFF);
    checks++; if (rate_active !== 16'd1) begin errors++; $display("FAIL rate1_apply: got %0d exp 1", rate_active); end
    send_ramp(8'h50, 6);
    idle(3);
    checks++; if (got.size() - base !== exp_q.size()) begin errors++; $display("FAIL rate01_count: got %0d exp %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (base + i < got.size()) begin
      checks++; if (got[base+i] !== exp_q[i]) begin errors++; $display("FAIL rate01_beat%0d: got %h exp %h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_midperiod();
    int base;
    logic [9:0] exp_q [$];
    exp_q = '{{8'h64,1'b0,1'b0}, {8'h65,1'b1,1'b1}, {8'h6E,1'b0,1'b0}, {8'h6F,1'b1,1'b1}};
    write_rate(16'd3, 16'hFFFF);
    base = got.size();
    send_beat(8'h60, 1'b0, 16'd0);
    send_beat(8'h61, 1'b0, 16'd0);
    send_beat(8'h62, 1'b1, 16'd5);
    checks++; if (rate_active !== 16'd3) begin errors++; $display("FAIL mid_rate_after_write: got %0d exp 3", rate_active); end
    send_beat(8'h63, 1'b0, 16'd0);
    send_beat(8'h64, 1'b0, 16'd0);
    checks++; if (rate_active !== 16'd3) begin errors++; $display("FAIL mid_rate_before_boundary: got %0d exp 3", rate_active); end
    send_beat(8'h65, 1'b0, 16'd0);
    checks++; if (rate_active !== 16'd5) begin errors++; $display("FAIL mid_rate_at_boundary: got %0d exp 5", rate_active); end
    send_ramp(8'h66, 10);
    idle(4);
    checks++; if (got.size() - base !== exp_q.size()) begin errors++; $display("FAIL mid_count: got %0d exp %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (base + i < got.size()) begin
      checks++; if (got[base+i] !== exp_q[i]) begin errors++; $display("FAIL mid_beat%0d: got %h exp %h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int stall0;
    int stab0;
    logic [9:0] exp_q [$];
    exp_q = '{{8'h72,1'b0,1'b0}, {8'h73,1'b1,1'b1}, {8'h76,1'b0,1'b0}, {8'h77,1'b1,1'b1}};
    write_rate(16'd2, 16'hFFFF);
    base   = got.size();
    stall0 = stall_cnt;
    stab0  = stab_err;
    rdy_q  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send_ramp(8'h70, 8);
    idle(5);
    checks++; if (stall_cnt - stall0 < 5) begin errors++; $display("FAIL bp_in_tready_low: got %0d stalled clks exp >= 5", stall_cnt - stall0); end
    checks++; if (stab_err - stab0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable clks exp 0", stab_err - stab0); end
    checks++; if (got.size() - base !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d exp %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (base + i < got.size()) begin
      checks++; if (got[base+i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h exp %h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    write_rate(16'd3, 16'hFFFF);
    for (int i = 0; i < 5; i++) send_beat(8'h80 + 8'(i), 1'b0, 16'd0);
    s_axis_in_tvalid = 1'b0;
    checks++; if (m_axis_out_tvalid !== 1'b1 || m_axis_out_tdata !== 8'h84)
      begin errors++; $display("FAIL rstmid_pre: got vld=%b dat=%h exp vld=1 dat=84", m_axis_out_tvalid, m_axis_out_tdata); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b exp 0", m_axis_out_tvalid); end
    checks++; if (m_axis_out_tdata !== 8'h00) begin errors++; $display("FAIL rstmid_tdata: got %h exp 00", m_axis_out_tdata); end
    checks++; if (m_axis_out_tuser !== 1'b0 || m_axis_out_tlast !== 1'b0)
      begin errors++; $display("FAIL rstmid_tag: got user=%b last=%b exp 0 0", m_axis_out_tuser, m_axis_out_tlast); end
    checks++; if (rate_active !== 16'd1) begin errors++; $display("FAIL rstmid_rate: got %0d exp 1", rate_active); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    base = got.size();
    send_ramp(8'h90, 2);
    idle(3);
    checks++; if (got.size() - base !== 2) begin errors++; $display("FAIL rstmid_count: got %0d exp 2", got.size() - base); end
    if (got.size() - base >= 2) begin
      checks++; if (got[base] !== {8'h90,1'b0,1'b0}) begin errors++; $display("FAIL rstmid_first_ch0: got %h exp %h", got[base], {8'h90,1'b0,1'b0}); end
      checks++; if (got[base+1] !== {8'h91,1'b1,1'b1}) begin errors++; $display("FAIL rstmid_second_ch1: got %h exp %h", got[base+1], {8'h91,1'b1,1'b1}); end
    end
  endtask

`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
  task automatic test_phase();
    int base;
    logic [9:0] exp_q [$];
    exp_q = '{{8'h02,1'b0,1'b0}, {8'h03,1'b1,1'b1}, {8'h0A,1'b0,1'b0}, {8'h0B,1'b1,1'b1},
              {8'h06,1'b0,1'b0}, {8'h07,1'b1,1'b1}};
    base = got.size();
    write_rate(16'd4, 16'd1);
    checks++; if (rate_active !== 16'd4) begin errors++; $display("FAIL phase_rate: got %0d exp 4", rate_active); end
    send_ramp(8'h00, 16);
    idle(3);
    write_rate(16'd4, 16'd9);
    send_ramp(8'h00, 8);
    idle(3);
    checks++; if (got.size() - base !== exp_q.size()) begin errors++; $display("FAIL phase_count: got %0d exp %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (base + i < got.size()) begin
      checks++; if (got[base+i] !== exp_q[i]) begin errors++; $display("FAIL phase_beat%0d: got %h exp %h", i, got[base+i], exp_q[i]); end
    end
  endtask
`endif

  initial begin
    reset_n            = 1'b0;
    s_axis_in_tdata    = '0;
    s_axis_in_tvalid   = 1'b0;
    s_axis_rate_tdata  = '0;
    s_axis_rate_tvalid = 1'b0;
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
    s_axis_phase_tdata = '0;
`endif
    m_axis_out_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_rate4();
    test_rate0_and_1();
    test_midperiod();
    test_backpressure();
    test_reset_midframe();
`ifdef DOWNSAMPLER_PHASE_OFFSET_EN
    test_phase();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
